// File: rtl/vrp_disp_rr.sv
// Round-robin dispatcher: one valid/ready stream fanned out to OH_WIDTH credited consumers.
// Define VRP_DISP_RR_ERR_EN to add the sticky err_credit_ovf flag for saturating credit returns.
module vrp_disp_rr #(
    parameter int  BIN_WIDTH  = 2,
    parameter int  DATA_WIDTH = 32,
    parameter int  CREDIT_MAX = 4,
    localparam int OH_WIDTH   = 1 << BIN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [OH_WIDTH-1:0]   v_out_vld,
    input  logic [OH_WIDTH-1:0]   v_out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [BIN_WIDTH-1:0]  out_idx,
    input  logic [OH_WIDTH-1:0]   v_credit_ret
`ifdef VRP_DISP_RR_ERR_EN
    ,
    output logic                  err_credit_ovf
`endif
);
    localparam int                CW        = $clog2(CREDIT_MAX + 1);
    localparam logic [CW-1:0]     CRED_FULL = CW'(CREDIT_MAX);
    localparam logic [OH_WIDTH-1:0] PTR_RST = OH_WIDTH'(1) << (OH_WIDTH - 1);

    logic [CW-1:0]         credit_q [OH_WIDTH];
    logic [CW-1:0]         credit_d [OH_WIDTH];
    logic [OH_WIDTH-1:0]   pre_sel_oh_q, pre_sel_oh_d;
    logic [OH_WIDTH-1:0]   vld_oh_q, vld_oh_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [BIN_WIDTH-1:0]  idx_q, idx_d;

    logic [OH_WIDTH-1:0]   cred_ok_s, hi_mask_s, cand_s, sel_oh_s;
    logic [BIN_WIDTH-1:0]  sel_idx_s;
    logic                  any_cred_s, hold_s, drain_s, slot_free_s, accept_s;

    // Candidates strictly above the last grant win; otherwise wrap to the lowest credited index.
    always_comb begin
        logic seen_v;
        seen_v    = 1'b0;
        cred_ok_s = '0;
        hi_mask_s = '0;
        sel_idx_s = '0;
        for (int k = 0; k < OH_WIDTH; k++) begin
            cred_ok_s[k] = (credit_q[k] != '0);
            hi_mask_s[k] = seen_v;
            seen_v       = seen_v | pre_sel_oh_q[k];
        end
        cand_s   = ((cred_ok_s & hi_mask_s) != '0) ? (cred_ok_s & hi_mask_s)
                                                   : (cred_ok_s & ~hi_mask_s);
        sel_oh_s = cand_s & (~cand_s + OH_WIDTH'(1));
        for (int k = 0; k < OH_WIDTH; k++) begin
            sel_idx_s = sel_idx_s | (sel_oh_s[k] ? BIN_WIDTH'(k) : '0);
        end
        any_cred_s = |cred_ok_s;
    end

    assign hold_s      = |vld_oh_q;
    assign drain_s     = hold_s && v_out_rdy[idx_q];
    assign slot_free_s = !hold_s || drain_s;
    assign in_rdy      = any_cred_s && slot_free_s;
    assign accept_s    = in_vld && in_rdy;

    // Output stage and pointer next state; a drain and an accept in one cycle reload with no bubble.
    always_comb begin
        vld_oh_d     = vld_oh_q;
        data_d       = data_q;
        idx_d        = idx_q;
        pre_sel_oh_d = pre_sel_oh_q;
        if (accept_s) begin
            vld_oh_d     = sel_oh_s;
            data_d       = in_data;
            idx_d        = sel_idx_s;
            pre_sel_oh_d = sel_oh_s;
        end else if (drain_s) begin
            vld_oh_d = '0;
        end else begin
            vld_oh_d = vld_oh_q;
        end
    end

    // Credit counters: return adds, consume subtracts, both cancel; a return at full is dropped.
    always_comb begin
        for (int k = 0; k < OH_WIDTH; k++) begin
            credit_d[k] = credit_q[k];
            case ({v_credit_ret[k], accept_s & sel_oh_s[k]})
                2'b10: begin
                    if (credit_q[k] == CRED_FULL) begin
                        credit_d[k] = credit_q[k];
                    end else begin
                        credit_d[k] = credit_q[k] + CW'(1);
                    end
                end
                2'b01:   credit_d[k] = credit_q[k] - CW'(1);
                default: credit_d[k] = credit_q[k];
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_oh_q     <= '0;
            data_q       <= '0;
            idx_q        <= '0;
            pre_sel_oh_q <= PTR_RST;
            for (int k = 0; k < OH_WIDTH; k++) begin
                credit_q[k] <= CRED_FULL;
            end
        end else begin
            vld_oh_q     <= vld_oh_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            pre_sel_oh_q <= pre_sel_oh_d;
            for (int k = 0; k < OH_WIDTH; k++) begin
                credit_q[k] <= credit_d[k];
            end
        end
    end

    assign v_out_vld = vld_oh_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;

`ifdef VRP_DISP_RR_ERR_EN
    logic err_q, err_d, ovf_s;

    // Overflow: a return landing on a full counter that is not being consumed this cycle.
    always_comb begin
        ovf_s = 1'b0;
        for (int k = 0; k < OH_WIDTH; k++) begin
            ovf_s = ovf_s | (v_credit_ret[k] & ~(accept_s & sel_oh_s[k])
                             & (credit_q[k] == CRED_FULL));
        end
        err_d = err_q | ovf_s;
    end

    // Sticky error register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_credit_ovf = err_q;
`endif
endmodule

// File: doc/vrp_disp_rr.md
Name: vrp_disp_rr

Overview:
- Round-robin dispatcher: one valid/ready input stream fanned out to OH_WIDTH consumers. This is the distribution-side counterpart of the round-robin arbiter.
- Each beat goes to the next consumer, in rotating order, that holds a credit.
- Per-destination credit counters; consumers return credits by pulse.
- One-entry registered output stage: 1-cycle latency, full throughput.

Parameters:
- BIN_WIDTH, 2, log2 of the destination count.
- OH_WIDTH, 1<<BIN_WIDTH, destination count (localparam).
- DATA_WIDTH, 32, payload width.
- CREDIT_MAX, 4, initial and maximum credits per destination (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  input beat accepted when in_vld && in_rdy.
- in_data  in  DATA_WIDTH  input payload.
- v_out_vld  out  OH_WIDTH  one-hot valid toward the selected destination.
- v_out_rdy  in  OH_WIDTH  per-destination ready.
- out_data  out  DATA_WIDTH  registered payload, shared by all destinations.
- out_idx  out  BIN_WIDTH  binary index of the held beat's destination.
- v_credit_ret  in  OH_WIDTH  per-destination credit return, one credit per cycle-high.
- err_credit_ovf  out  1  sticky overflow flag; present only with VRP_DISP_RR_ERR_EN.

Behaviour:
- Reset values:
  - v_out_vld = 0, out_data = 0, out_idx = 0.
  - Every credit counter = CREDIT_MAX.
  - Last-grant pointer pre_sel_oh = one-hot MSB (bit OH_WIDTH-1), so destination 0 has highest priority after reset.
  - err_credit_ovf = 0.
- Credit counters are $clog2(CREDIT_MAX+1) bits wide. cred_ok[k] = (credit[k] != 0).
- Selection, combinational:
  - Candidates are the bits of cred_ok.
  - High-priority region: indices strictly above the set bit of pre_sel_oh.
  - Low-priority region: indices up to and including that bit.
  - Pick the lowest candidate in the high region; if none, the lowest in the low region.
  - any_cred = |cred_ok.
- Output stage holds at most one beat (hold_q).
  - drain = hold_q && v_out_rdy[out_idx].
  - slot_free = !hold_q || drain.
- in_rdy = any_cred && slot_free. Combinational from v_out_rdy; no dependence on in_vld.
- Accept when in_vld && in_rdy. On the next edge:
  - out_data <= in_data, out_idx <= selected index, hold_q <= 1.
  - pre_sel_oh <= selected one-hot.
  - credit[sel] decrements by 1.
- Drain without accept: hold_q <= 0 next cycle. out_data and out_idx hold their last values.
- Drain with accept in the same cycle: new beat loaded with no bubble. Sustained throughput is 1 beat/cycle.
- v_out_vld = hold_q ? (1 << out_idx) : 0. Stable while held (valid/ready rule: no withdrawal, data constant until handshake).
- The pointer updates only on accept. Back-pressure or in_vld low does not rotate it.
- Credit update per destination per cycle: net = +v_credit_ret[k] − (accepted to k).
  - Simultaneous return and consume on the same k: counter unchanged.
- Credit return at CREDIT_MAX with no consume that cycle:
  - Counter saturates at CREDIT_MAX; the return is dropped.
  - Sets the overflow condition (see Optional Feature).
- All credits zero: in_rdy = 0. The held beat, if any, still drains.
- Reset mid-operation: the held beat is discarded, credits restore to CREDIT_MAX, pointer returns to MSB.

Optional Feature:
- Macro: VRP_DISP_RR_ERR_EN.
- Defined:
  - err_credit_ovf port exists.
  - Goes high the cycle after any saturating credit return.
  - Sticky until rst_n.
- Undefined:
  - Port and flag logic absent.
  - Saturation behaviour unchanged (return silently dropped).

Test Plan:
- Reset release, BIN_WIDTH=2, CREDIT_MAX=4, all v_out_rdy=1, in_vld=1 with data 0xA0, 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles -> v_out_vld = 0001, 0010, 0100, 1000, 0001 one cycle after each accept; out_data matches each beat; in_rdy stays 1.
- No credit returns, continuous traffic -> after 16 accepts all credits are 0 and in_rdy=0. Pulse v_credit_ret=0100 -> next accept goes to destination 2 only.
- Credits: dest1 = 0, others nonzero, pointer at dest0 -> next beat goes to dest2 (dest1 skipped); pointer = 0100.
- Beat held for dest3 with v_out_rdy[3]=0 for 5 cycles -> v_out_vld=1000 and out_data stable; in_rdy=0. Raise v_out_rdy[3] with in_vld=1 -> same-cycle drain and accept, no bubble.
- dest0 at credit 3: accept to dest0 and v_credit_ret[0]=1 in the same cycle -> credit stays 3.
- VRP_DISP_RR_ERR_EN: v_credit_ret=0001 right after reset (credit 4) -> credit stays 4; err_credit_ovf=1 next cycle and persists. Assert rst_n low mid-burst -> v_out_vld=0, credits=4, err cleared.
